// File: rtl/lfsr_bank_debruijn_pkg.sv
// Shared types and helpers for the de Bruijn LFSR bank.
package lfsr_bank_debruijn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN
  } bankState_t;

  // Lane k seed: (base ^ (k * salt)) truncated to width bits.
  function automatic logic [31:0] laneSeed(
    input logic [31:0] base,
    input int unsigned k,
    input logic [31:0] salt,
    input int unsigned width
  );
    logic [31:0] mask;
    logic [31:0] prod;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    prod = k * salt;
    return (base ^ prod) & mask;
  endfunction

endpackage

// File: rtl/lfsr_bank_debruijn_step.sv
// Combinational single step of a Fibonacci LFSR with all-zero-state insertion.
module lfsr_step_debruijn #(
  parameter int unsigned      WIDTH = 14,
  parameter logic [WIDTH-1:0] TAPS  = 14'h3802
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  logic fb;
  logic zeroLow;

  // Feedback parity, inverted when the low bits are all zero to splice state 0 into the cycle.
  always_comb begin
    fb      = ^(cur & TAPS);
    zeroLow = (cur[WIDTH-2:0] == '0);
    nxt     = {cur[WIDTH-2:0], fb ^ zeroLow};
  end

endmodule

// File: rtl/lfsr_bank_debruijn.sv
// Multi-lane de Bruijn LFSR bank with seed derivation, warm-up and valid/ready output.
module lfsr_bank_debruijn
  import lfsr_bank_debruijn_pkg::*;
#(
  parameter int unsigned      WIDTH      = 14,
  parameter int unsigned      LANES      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 14'h3802,
  parameter int unsigned      STEP       = 1,
  parameter int unsigned      WARMUP     = 16,
  parameter logic [WIDTH-1:0] LANE_SALT  = 14'h1F35,
  parameter logic [WIDTH-1:0] RESET_SEED = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   seed_load,
  input  logic [WIDTH-1:0]       seed,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned     CW          = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0]   WARM_LAST   = CW'(WARMUP - 1);
  localparam bankState_t      START_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  bankState_t    state;
  logic [CW-1:0] warmCnt;
  logic          advance;

  // Lanes step during warm-up, or in RUN only on an accepted transfer; a load suppresses stepping.
  assign advance   = !seed_load && enable &&
                     ((state == ST_WARMUP) || ((state == ST_RUN) && out_ready));
  assign out_valid = (state == ST_RUN) && enable;

  // Control FSM and warm-up counter; seed_load overrides everything, enable=0 freezes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      warmCnt <= '0;
    end else if (seed_load) begin
      state   <= START_STATE;
      warmCnt <= '0;
    end else if (enable) begin
      unique case (state)
        ST_IDLE: begin
          state   <= START_STATE;
          warmCnt <= '0;
        end
        ST_WARMUP: begin
          warmCnt <= warmCnt + 1'b1;
          if (warmCnt == WARM_LAST) state <= ST_RUN;
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : gLane
    localparam logic [WIDTH-1:0] RST_SEED =
      WIDTH'(laneSeed(32'(RESET_SEED), k, 32'(LANE_SALT), WIDTH));

    logic [WIDTH-1:0] lane;
    logic [WIDTH-1:0] loadSeed;
    logic [WIDTH-1:0] chain [STEP+1];

    assign loadSeed = WIDTH'(laneSeed(32'(seed), k, 32'(LANE_SALT), WIDTH));
    assign chain[0] = lane;

    // STEP single steps chained combinationally give the leap-forward advance.
    for (genvar j = 0; j < STEP; j++) begin : gStep
      lfsr_step_debruijn #(
        .WIDTH(WIDTH),
        .TAPS (TAPS)
      ) uStep (
        .cur(chain[j]),
        .nxt(chain[j+1])
      );
    end

    // Lane register: reset seed, reload seed, or leap-forward advance.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)          lane <= RST_SEED;
      else if (seed_load) lane <= loadSeed;
      else if (advance)   lane <= chain[STEP];
    end

    assign data_out[k*WIDTH +: WIDTH] = lane;
  end

endmodule

// File: tb/tb_lfsr_bank_debruijn.sv
module tb_lfsr_bank_debruijn;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // A: 2 lanes, 4 bits, warm-up 3
  logic       enA, ldA, rdyA, validA;
  logic [3:0] seedA;
  logic [7:0] dataA;
  // B/D: 1 lane, 4 bits, no warm-up; B STEP=1, D STEP=2
  logic       enB, rdyB, ldB, validB, validD;
  logic [3:0] seedB, dataB, dataD;
  // C: default 14-bit, 4 lanes, warm-up 16
  logic        enC, ldC, rdyC, validC;
  logic [13:0] seedC;
  logic [55:0] dataC;

  lfsr_bank_debruijn #(.WIDTH(4), .LANES(2), .TAPS(4'h9), .STEP(1), .WARMUP(3),
                       .LANE_SALT(4'h5), .RESET_SEED(4'h0)) dutA (
    .clk(clk), .reset(reset), .enable(enA), .seed_load(ldA), .seed(seedA),
    .data_out(dataA), .out_valid(validA), .out_ready(rdyA));

  lfsr_bank_debruijn #(.WIDTH(4), .LANES(1), .TAPS(4'h9), .STEP(1), .WARMUP(0),
                       .LANE_SALT(4'h5), .RESET_SEED(4'h0)) dutB (
    .clk(clk), .reset(reset), .enable(enB), .seed_load(ldB), .seed(seedB),
    .data_out(dataB), .out_valid(validB), .out_ready(rdyB));

  lfsr_bank_debruijn #(.WIDTH(4), .LANES(1), .TAPS(4'h9), .STEP(2), .WARMUP(0),
                       .LANE_SALT(4'h5), .RESET_SEED(4'h0)) dutD (
    .clk(clk), .reset(reset), .enable(enB), .seed_load(ldB), .seed(seedB),
    .data_out(dataD), .out_valid(validD), .out_ready(rdyB));

  lfsr_bank_debruijn #(.WIDTH(14), .LANES(4), .TAPS(14'h3802), .STEP(1), .WARMUP(16),
                       .LANE_SALT(14'h1F35), .RESET_SEED(14'h0)) dutC (
    .clk(clk), .reset(reset), .enable(enC), .seed_load(ldC), .seed(seedC),
    .data_out(dataC), .out_valid(validC), .out_ready(rdyC));

  int errors = 0;
  int checks = 0;

  localparam int WARM_A = 3;
  int mLane[2];
  int mMode;      // 0 idle, 1 discarding, 2 streaming
  int mWarm;      // discards still owed

  int seq1[16] = '{0, 1, 3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8};
  int seq2[9]  = '{0, 3, 15, 13, 5, 6, 9, 4, 0};

  function automatic int refStep(int s, int w, int taps);
    int fb;
    int low;
    fb  = $countones(s & taps) & 1;
    low = s & ((1 << (w - 1)) - 1);
    return (low << 1) | (fb ^ int'(low == 0));
  endfunction

  function automatic int refSeed(int base, int k, int salt, int w);
    return (base ^ (k * salt)) & ((1 << w) - 1);
  endfunction

  function automatic logic [7:0] expA();
    return 8'((mLane[1] << 4) | mLane[0]);
  endfunction

  function automatic logic expValidA();
    return (mMode == 2) && enA;
  endfunction

  task automatic modelResetA();
    for (int k = 0; k < 2; k++) mLane[k] = refSeed(0, k, 5, 4);
    mMode = 0;
    mWarm = 0;
  endtask

  // Drive one cycle of inputs to A, advance the model, then land #1 after the edge.
  task automatic stepA(input bit en, input bit ld, input int sd, input bit rdy);
    enA = en; ldA = ld; seedA = 4'(sd); rdyA = rdy;
    if (ld) begin
      for (int k = 0; k < 2; k++) mLane[k] = refSeed(sd & 15, k, 5, 4);
      mMode = (WARM_A > 0) ? 1 : 2;
      mWarm = WARM_A;
    end else if (en) begin
      if (mMode == 0) begin
        mMode = (WARM_A > 0) ? 1 : 2;
        mWarm = WARM_A;
      end else if (mMode == 1) begin
        for (int k = 0; k < 2; k++) mLane[k] = refStep(mLane[k], 4, 9);
        mWarm--;
        if (mWarm == 0) mMode = 2;
      end else if (rdy) begin
        for (int k = 0; k < 2; k++) mLane[k] = refStep(mLane[k], 4, 9);
      end
    end
    @(posedge clk);
    #1;
    ldA = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    enA = 0; ldA = 0; rdyA = 0; seedA = '0;
    enB = 0; ldB = 0; rdyB = 0; seedB = '0;
    enC = 0; ldC = 0; rdyC = 0; seedC = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelResetA();
    #1;
  endtask

  task automatic test_reset();
    logic [55:0] expC;
    reset = 1'b1;
    enA = 0; ldA = 0; rdyA = 0; seedA = '0;
    enB = 0; ldB = 0; rdyB = 0; seedB = '0;
    enC = 0; ldC = 0; rdyC = 0; seedC = '0;
    @(posedge clk);
    #1;
    modelResetA();
    for (int k = 0; k < 4; k++) expC[k*14 +: 14] = 14'(refSeed(0, k, 'h1F35, 14));
    checks++; if (dataA !== 8'h50) begin errors++; $display("FAIL reset_dataA: got %h expected %h", dataA, 8'h50); end
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL reset_validA: got %b expected 0", validA); end
    checks++; if (dataB !== 4'h0) begin errors++; $display("FAIL reset_dataB: got %h expected 0", dataB); end
    checks++; if (validB !== 1'b0) begin errors++; $display("FAIL reset_validB: got %b expected 0", validB); end
    checks++; if (dataC !== expC) begin errors++; $display("FAIL reset_dataC: got %h expected %h", dataC, expC); end
    checks++; if (validC !== 1'b0) begin errors++; $display("FAIL reset_validC: got %b expected 0", validC); end
    @(negedge clk);
    reset = 1'b0;
    // Idle with enable low must hold the seeds.
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dataA !== expA()) begin errors++; $display("FAIL idle_hold_dataA: got %h expected %h", dataA, expA()); end
  endtask

  task automatic test_sequences();
    enB = 1'b1; rdyB = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk);
      #1;
      checks++; if (validB !== 1'b1) begin errors++; $display("FAIL seq1_valid n=%0d: got %b expected 1", n, validB); end
      checks++; if (dataB !== 4'(seq1[(n - 1) % 16])) begin errors++; $display("FAIL seq1 n=%0d: got %h expected %h", n, dataB, seq1[(n - 1) % 16]); end
      if (n <= 9) begin
        checks++; if (dataD !== 4'(seq2[n - 1])) begin errors++; $display("FAIL seq2 n=%0d: got %h expected %h", n, dataD, seq2[n - 1]); end
      end
    end
    enB = 1'b0;
  endtask

  task automatic test_warmup_load();
    stepA(1, 1, 0, 1);
    checks++; if (dataA !== 8'h50) begin errors++; $display("FAIL load_seeds: got %h expected 50", dataA); end
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL load_valid: got %b expected 0", validA); end
    for (int i = 0; i < 3; i++) begin
      stepA(1, 0, 0, 1);
      checks++; if (validA !== (i == 2)) begin errors++; $display("FAIL warm_valid i=%0d: got %b expected %b", i, validA, i == 2); end
      checks++; if (dataA !== expA()) begin errors++; $display("FAIL warm_data i=%0d: got %h expected %h", i, dataA, expA()); end
    end
    checks++; if (dataA[3:0] !== 4'h7) begin errors++; $display("FAIL first_valid_lane0: got %h expected 7", dataA[3:0]); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    held = dataA;
    for (int i = 0; i < 5; i++) begin
      stepA(1, 0, 0, 0);
      checks++; if (dataA !== held) begin errors++; $display("FAIL stall_hold i=%0d: got %h expected %h", i, dataA, held); end
      checks++; if (validA !== 1'b1) begin errors++; $display("FAIL stall_valid i=%0d: got %b expected 1", i, validA); end
    end
    for (int i = 0; i < 3; i++) begin
      stepA(0, 0, 0, 1);
      checks++; if (dataA !== held) begin errors++; $display("FAIL disabled_hold i=%0d: got %h expected %h", i, dataA, held); end
      checks++; if (validA !== 1'b0) begin errors++; $display("FAIL disabled_valid i=%0d: got %b expected 0", i, validA); end
    end
    stepA(1, 0, 0, 1);
    held = 8'((refStep(int'(held[7:4]), 4, 9) << 4) | refStep(int'(held[3:0]), 4, 9));
    checks++; if (dataA !== held) begin errors++; $display("FAIL resume_advance: got %h expected %h", dataA, held); end
    checks++; if (validA !== 1'b1) begin errors++; $display("FAIL resume_valid: got %b expected 1", validA); end
  endtask

  task automatic test_reload_collisions();
    int s1, s2, s3;
    s1 = int'($urandom_range(0, 15));
    s2 = int'($urandom_range(0, 15));
    s3 = int'($urandom_range(0, 15));
    stepA(1, 1, s1, 1);
    stepA(1, 0, 0, 1);
    stepA(1, 1, s2, 1);
    checks++; if (dataA !== expA()) begin errors++; $display("FAIL warm_reload_data: got %h expected %h", dataA, expA()); end
    for (int i = 0; i < 3; i++) begin
      stepA(1, 0, 0, 1);
      checks++; if (validA !== (i == 2)) begin errors++; $display("FAIL warm_restart i=%0d: got %b expected %b", i, validA, i == 2); end
    end
    checks++; if (validA !== 1'b1) begin errors++; $display("FAIL pre_collide_valid: got %b expected 1", validA); end
    stepA(1, 1, s3, 1);
    checks++; if (dataA !== 8'((refSeed(s3, 1, 5, 4) << 4) | refSeed(s3, 0, 5, 4))) begin
      errors++; $display("FAIL collide_seeds: got %h expected %h", dataA, expA()); end
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL collide_valid: got %b expected 0", validA); end
    for (int i = 0; i < 3; i++) stepA(1, 0, 0, 1);
    checks++; if (dataA !== expA() || validA !== 1'b1) begin
      errors++; $display("FAIL collide_restart: got %h/%b expected %h/1", dataA, validA, expA()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stepA($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
      checks++; if (dataA !== expA()) begin errors++; $display("FAIL rand_data i=%0d: got %h expected %h", i, dataA, expA()); end
      checks++; if (validA !== expValidA()) begin errors++; $display("FAIL rand_valid i=%0d: got %b expected %b", i, validA, expValidA()); end
    end
  endtask

  task automatic test_reset_midrun();
    stepA(1, 1, 9, 1);
    for (int i = 0; i < 5; i++) stepA(1, 0, 0, 1);
    checks++; if (validA !== 1'b1) begin errors++; $display("FAIL midrun_pre_valid: got %b expected 1", validA); end
    reset = 1'b1;
    #2;
    checks++; if (dataA !== 8'h50) begin errors++; $display("FAIL midrun_reset_data: got %h expected 50", dataA); end
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL midrun_reset_valid: got %b expected 0", validA); end
    doReset();
    checks++; if (dataA !== expA() || validA !== 1'b0) begin
      errors++; $display("FAIL post_reset: got %h/%b expected %h/0", dataA, validA, expA()); end
  endtask

  task automatic test_full_period();
    int mC[4];
    logic [55:0] expC;
    bit seen[16384];
    int period;
    int lane0;
    for (int k = 0; k < 4; k++) mC[k] = refSeed(0, k, 'h1F35, 14);
    for (int v = 0; v < 16384; v++) seen[v] = 1'b0;
    seen[0] = 1'b1;
    enC = 1'b1; rdyC = 1'b1; ldC = 1'b1; seedC = '0;
    @(posedge clk);
    #1;
    ldC = 1'b0;
    for (int k = 0; k < 4; k++) expC[k*14 +: 14] = 14'(mC[k]);
    checks++; if (dataC !== expC) begin errors++; $display("FAIL period_load: got %h expected %h", dataC, expC); end
    period = 0;
    lane0 = 1;
    while (lane0 != 0 && period < 20000) begin
      @(posedge clk);
      #1;
      period++;
      for (int k = 0; k < 4; k++) begin
        mC[k] = refStep(mC[k], 14, 'h3802);
        expC[k*14 +: 14] = 14'(mC[k]);
      end
      checks++; if (dataC !== expC) begin errors++; $display("FAIL period_data p=%0d: got %h expected %h", period, dataC, expC); end
      checks++; if (validC !== (period >= 16)) begin errors++; $display("FAIL period_valid p=%0d: got %b expected %b", period, validC, period >= 16); end
      lane0 = int'(dataC[13:0]);
      if (lane0 != 0) begin
        checks++; if (seen[lane0]) begin errors++; $display("FAIL period_repeat p=%0d: got state %h again expected new state", period, lane0); end
        seen[lane0] = 1'b1;
      end
    end
    checks++; if (period != 16384) begin errors++; $display("FAIL period_length: got %0d expected 16384", period); end
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_warmup_load();
    test_backpressure();
    test_reload_collisions();
    test_random();
    test_reset_midrun();
    test_full_period();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
